// File: rtl/reg_wb_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_wb_pkg : shared sizes and requester IDs for the write-back path   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package reg_wb_pkg;

    localparam int WORD_SIZE = 16;
    localparam int ADDR_SIZE = 4;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

endpackage
`default_nettype wire

// File: rtl/reg_wb_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_wb_arbiter_if : requester handshakes and register-file write port |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface reg_wb_arbiter_if;
    import reg_wb_pkg::*;

    logic                 REQ0_VALID;
    logic [ADDR_SIZE-1:0] REQ0_ADDR;
    logic [WORD_SIZE-1:0] REQ0_DATA;
    logic                 REQ0_READY;
    logic                 REQ1_VALID;
    logic [ADDR_SIZE-1:0] REQ1_ADDR;
    logic [WORD_SIZE-1:0] REQ1_DATA;
    logic                 REQ1_READY;
    logic                 W_ON;
    logic [ADDR_SIZE-1:0] WADDR;
    logic [WORD_SIZE-1:0] WDATA;
    logic                 GRANT_ID;

    // Arbiter side
    modport slave (
        input  REQ0_VALID, REQ0_ADDR, REQ0_DATA,
        input  REQ1_VALID, REQ1_ADDR, REQ1_DATA,
        output REQ0_READY, REQ1_READY,
        output W_ON, WADDR, WDATA, GRANT_ID
    );

    // Requesters plus register file
    modport master (
        output REQ0_VALID, REQ0_ADDR, REQ0_DATA,
        output REQ1_VALID, REQ1_ADDR, REQ1_DATA,
        input  REQ0_READY, REQ1_READY,
        input  W_ON, WADDR, WDATA, GRANT_ID
    );

endinterface
`default_nettype wire

// File: rtl/reg_wb_arbiter_slot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_slot : one-entry holding buffer with drain-and-refill ready logic  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module wb_slot
    import reg_wb_pkg::*;
(
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_valid,
    input  wire logic [ADDR_SIZE-1:0] i_addr,
    input  wire logic [WORD_SIZE-1:0] i_data,
    input  wire logic                 i_drain,
    output logic                      o_ready,
    output logic                      o_load,
    output logic                      o_buf_v,
    output logic [ADDR_SIZE-1:0]      o_buf_addr,
    output logic [WORD_SIZE-1:0]      o_buf_data
);

    logic                 r_v;
    logic [ADDR_SIZE-1:0] r_addr;
    logic [WORD_SIZE-1:0] r_data;

    // A draining entry frees the slot, so a new one may land on the same edge.
    assign o_ready    = !rst && (!r_v || i_drain);
    assign o_load     = i_valid && o_ready;
    assign o_buf_v    = r_v;
    assign o_buf_addr = r_addr;
    assign o_buf_data = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v    <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (o_load) begin
            r_v    <= 1'b1;
            r_addr <= i_addr;
            r_data <= i_data;
        end else if (i_drain) begin
            r_v    <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_wb_arbiter : oldest-first, round-robin-on-tie write-back arbiter  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module reg_wb_arbiter
    import reg_wb_pkg::*;
(
    input  wire logic       CLK,
    input  wire logic       RST,
    reg_wb_arbiter_if.slave bus
);

    logic [1:0]           w_req_valid;
    logic [ADDR_SIZE-1:0] w_req_addr [2];
    logic [WORD_SIZE-1:0] w_req_data [2];
    logic [1:0]           w_ready;
    logic [1:0]           w_load;
    logic [1:0]           w_buf_v;
    logic [ADDR_SIZE-1:0] w_buf_addr [2];
    logic [WORD_SIZE-1:0] w_buf_data [2];
    logic [1:0]           w_drain;
    logic [1:0]           w_next_v;
    logic                 w_grant_v;
    logic                 w_grant_id;
    logic                 w_last_next;
    logic                 w_older_next;

    logic                 r_w_on;
    logic [ADDR_SIZE-1:0] r_waddr;
    logic [WORD_SIZE-1:0] r_wdata;
    logic                 r_grant_id;
    logic                 r_last;
    logic                 r_older;

    assign w_req_valid   = {bus.REQ1_VALID, bus.REQ0_VALID};
    assign w_req_addr[0] = bus.REQ0_ADDR;
    assign w_req_addr[1] = bus.REQ1_ADDR;
    assign w_req_data[0] = bus.REQ0_DATA;
    assign w_req_data[1] = bus.REQ1_DATA;

    generate
        for (genvar i = 0; i < 2; i++) begin : g_slot
            wb_slot u_slot (
                .clk        (CLK),
                .rst        (RST),
                .i_valid    (w_req_valid[i]),
                .i_addr     (w_req_addr[i]),
                .i_data     (w_req_data[i]),
                .i_drain    (w_drain[i]),
                .o_ready    (w_ready[i]),
                .o_load     (w_load[i]),
                .o_buf_v    (w_buf_v[i]),
                .o_buf_addr (w_buf_addr[i]),
                .o_buf_data (w_buf_data[i])
            );
        end
    endgenerate

    assign w_grant_v  = |w_buf_v;
    assign w_grant_id = (&w_buf_v) ? r_older : w_buf_v[1];
    assign w_drain[0] = w_grant_v && (w_grant_id == REQ_ALU);
    assign w_drain[1] = w_grant_v && (w_grant_id == REQ_MEM);
    assign w_next_v   = w_load | (w_buf_v & ~w_drain);

    // The round-robin tie uses the grant made on this same edge, if any.
    assign w_last_next = w_grant_v ? w_grant_id : r_last;

    always_comb begin
        w_older_next = r_older;
        if (w_load[0] && w_load[1]) begin
            w_older_next = !w_last_next;
        end else if (w_load[0] && w_next_v[1]) begin
            w_older_next = 1'b1;
        end else if (w_load[1] && w_next_v[0]) begin
            w_older_next = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_w_on     <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_grant_id <= REQ_ALU;
            r_last     <= REQ_MEM;
            r_older    <= 1'b0;
        end else begin
            r_older <= w_older_next;
            r_last  <= w_last_next;
            r_w_on  <= w_grant_v;
            if (w_grant_v) begin
                r_waddr    <= w_buf_addr[w_grant_id];
                r_wdata    <= w_buf_data[w_grant_id];
                r_grant_id <= w_grant_id;
            end
        end
    end

    assign bus.REQ0_READY = w_ready[0];
    assign bus.REQ1_READY = w_ready[1];
    assign bus.W_ON       = r_w_on;
    assign bus.WADDR      = r_waddr;
    assign bus.WDATA      = r_wdata;
    assign bus.GRANT_ID   = r_grant_id;

endmodule
`default_nettype wire
